// File: rtl/oled_pkg.sv
// Shared SSD1306 definitions: SPI transmitter state encoding, panel command bytes and D/C levels.
package oled_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP,
    ST_DONE
  } tx_state_e;

  localparam int unsigned DIV_W = 8;
  localparam int unsigned BIT_W = 3;

  // SSD1306 init-sequence command bytes, shared with the init sequencer
  localparam logic [7:0] CMD_DISPLAY_OFF    = 8'hAE;
  localparam logic [7:0] CMD_DISPLAY_ON     = 8'hAF;
  localparam logic [7:0] CMD_SET_CLK_DIV    = 8'hD5;
  localparam logic [7:0] CMD_CLK_DIV_VAL    = 8'h80;
  localparam logic [7:0] CMD_CHARGE_PUMP    = 8'h8D;
  localparam logic [7:0] CMD_CHARGE_PUMP_ON = 8'h14;
  localparam logic [7:0] CMD_SET_CONTRAST   = 8'h81;
  localparam logic [7:0] CMD_CONTRAST_VAL   = 8'hCF;
  localparam logic [7:0] CMD_SET_PRECHARGE  = 8'hD9;
  localparam logic [7:0] CMD_PRECHARGE_VAL  = 8'hF1;
  localparam logic [7:0] CMD_SEG_REMAP      = 8'hA0;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

endpackage

// File: rtl/oled_sclk_div.sv
// SCLK half-period tick generator: tick_c fires on the last of every CLK_DIV enabled cycles.
module oled_sclk_div
  import oled_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick_c
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  assign tick_c = en && (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (clr) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/oled_spi_tx.sv
// SSD1306 SPI byte transmitter: mode 0, MSB first, CS-framed, one send_done pulse per byte.
module oled_spi_tx
  import oled_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_send,
  input  logic [7:0] spi_data,
  input  logic       dc_in,
  output logic       send_done,
  output logic       busy,
  output logic       oled_sclk,
  output logic       oled_sdin,
  output logic       oled_cs_n,
  output logic       oled_dc
);

  localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'(CS_GAP - 1);

  tx_state_e        state;
  logic [7:0]       shift_reg;
  logic [BIT_W-1:0] bit_cnt;
  logic [DIV_W-1:0] gap_cnt;
  logic             tick_c;
  logic             accept_c;

  assign accept_c = (state == ST_IDLE) && spi_send;

  oled_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk    (clk),
    .reset  (reset),
    .en     (state == ST_SHIFT),
    .clr    (accept_c),
    .tick_c (tick_c)
  );

  // MOSI is registered and only updated on the SCLK falling transition
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      send_done <= 1'b0;
      busy      <= 1'b0;
      oled_sclk <= 1'b0;
      oled_sdin <= 1'b0;
      oled_cs_n <= 1'b1;
      oled_dc   <= 1'b0;
    end else begin
      send_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (spi_send) begin
            shift_reg <= spi_data;
            oled_sdin <= spi_data[7];
            oled_dc   <= dc_in;
            oled_cs_n <= 1'b0;
            bit_cnt   <= BIT_W'(7);
            busy      <= 1'b1;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (tick_c) begin
            if (!oled_sclk) begin
              oled_sclk <= 1'b1;
            end else begin
              oled_sclk <= 1'b0;
              if (bit_cnt == '0) begin
                oled_cs_n <= 1'b1;
                oled_sdin <= 1'b0;
                gap_cnt   <= '0;
                state     <= ST_GAP;
              end else begin
                shift_reg <= {shift_reg[6:0], 1'b0};
                oled_sdin <= shift_reg[6];
                bit_cnt   <= bit_cnt - BIT_W'(1);
              end
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            send_done <= 1'b1;
            state     <= ST_DONE;
          end else begin
            gap_cnt <= gap_cnt + DIV_W'(1);
          end
        end
        ST_DONE: begin
          // spi_send is deliberately not sampled here so the requester can present the next byte
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_spi_tx.sv
// Self-checking bench for oled_spi_tx: default and fastest divider instances against a byte-level model.
module tb_oled_spi_tx;

  logic       clk;
  logic       reset;
  logic [7:0] data;
  logic       dc_in;
  logic       send_a, send_b;
  logic       done_a, busy_a, sclk_a, sdin_a, cs_n_a, dc_a;
  logic       done_b, busy_b, sclk_b, sdin_b, cs_n_b, dc_b;

  oled_spi_tx dut_a (
    .clk(clk), .reset(reset), .spi_send(send_a), .spi_data(data), .dc_in(dc_in),
    .send_done(done_a), .busy(busy_a), .oled_sclk(sclk_a), .oled_sdin(sdin_a),
    .oled_cs_n(cs_n_a), .oled_dc(dc_a)
  );

  oled_spi_tx #(.CLK_DIV(1), .CS_GAP(1)) dut_b (
    .clk(clk), .reset(reset), .spi_send(send_b), .spi_data(data), .dc_in(dc_in),
    .send_done(done_b), .busy(busy_b), .oled_sclk(sclk_b), .oled_sdin(sdin_b),
    .oled_cs_n(cs_n_b), .oled_dc(dc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int dcnt_a   = 0;
  int dcnt_b   = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  int acc_a[$];
  logic [7:0] sh_a, sh_b;
  int nb_a = 0, nb_b = 0;
  logic bq_a = 1'b0;
  bit sel = 1'b0;

  logic s_done, s_busy, s_sclk, s_sdin, s_cs_n, s_dc;
  assign s_done = sel ? done_b : done_a;
  assign s_busy = sel ? busy_b : busy_a;
  assign s_sclk = sel ? sclk_b : sclk_a;
  assign s_sdin = sel ? sdin_b : sdin_a;
  assign s_cs_n = sel ? cs_n_b : cs_n_a;
  assign s_dc   = sel ? dc_b   : dc_a;

  always @(posedge clk) cyc++;

  // Panel-side decoder: sample MOSI on each SCLK rising edge, partial bytes dropped on reset
  always @(posedge sclk_a or posedge reset) begin
    if (reset) nb_a = 0;
    else begin
      sh_a = {sh_a[6:0], sdin_a};
      nb_a++;
      if (nb_a == 8) begin q_a.push_back(sh_a); nb_a = 0; end
    end
  end

  always @(posedge sclk_b or posedge reset) begin
    if (reset) nb_b = 0;
    else begin
      sh_b = {sh_b[6:0], sdin_b};
      nb_b++;
      if (nb_b == 8) begin q_b.push_back(sh_b); nb_b = 0; end
    end
  end

  always @(negedge clk) begin
    if (done_a === 1'b1) dcnt_a++;
    if (done_b === 1'b1) dcnt_b++;
    if (busy_a === 1'b1 && bq_a === 1'b0) acc_a.push_back(cyc);
    bq_a = busy_a;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request; expected latency, framing and byte come from the transfer rules, not the RTL
  task automatic run_byte(input bit fast, input logic [7:0] d, input logic dc,
                          input int drop_at, input logic [7:0] alt, input string tag);
    int dv, gv, lat, d0;
    bit dc_bad, cs_bad, sck_bad, busy_bad;
    logic [7:0] got;
    int qn;
    dv = fast ? 1 : 4;
    gv = fast ? 1 : 2;
    lat = 0; dc_bad = 0; cs_bad = 0; sck_bad = 0; busy_bad = 0;
    sel = fast;
    @(negedge clk);
    if (fast) q_b.delete(); else q_a.delete();
    d0 = fast ? dcnt_b : dcnt_a;
    data = d; dc_in = dc;
    if (fast) send_b = 1'b1; else send_a = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 600 && lat == 0; n++) begin
      @(negedge clk);
      if (n == drop_at) begin send_a = 1'b0; send_b = 1'b0; data = alt; dc_in = ~dc; end
      if (s_dc !== dc) dc_bad = 1;
      if (s_busy !== 1'b1) busy_bad = 1;
      if (n <= 16 * dv) begin
        if (s_cs_n !== 1'b0) cs_bad = 1;
        if (s_sclk !== 1'(((n - 1) / dv) % 2)) sck_bad = 1;
      end else if (s_cs_n !== 1'b1 || s_sclk !== 1'b0 || s_sdin !== 1'b0) begin
        cs_bad = 1;
      end
      if (s_done === 1'b1) lat = n;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(16 * dv + gv + 1));
    chk({tag, "_dc_held"}, 32'(dc_bad), 32'd0);
    chk({tag, "_busy_held"}, 32'(busy_bad), 32'd0);
    chk({tag, "_cs_frame"}, 32'(cs_bad), 32'd0);
    chk({tag, "_sclk_shape"}, 32'(sck_bad), 32'd0);
    @(negedge clk);
    chk({tag, "_done_single"}, 32'(s_done), 32'd0);
    chk({tag, "_busy_clear"}, 32'(s_busy), 32'd0);
    qn  = fast ? q_b.size() : q_a.size();
    got = (qn > 0) ? (fast ? q_b[0] : q_a[0]) : 8'hxx;
    chk({tag, "_nbytes"}, 32'(qn), 32'd1);
    chk({tag, "_byte"}, 32'(got), 32'(d));
    chk({tag, "_done_count"}, 32'((fast ? dcnt_b : dcnt_a) - d0), 32'd1);
  endtask

  initial begin
    bit bad;
    bit got;
    int d0;
    logic [7:0] rd;
    logic [7:0] seq[3];
    reset = 1'b1; send_a = 1'b0; send_b = 1'b0; data = 8'h00; dc_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(cs_n_a), 32'd1);
    chk("rst_sclk", 32'(sclk_a), 32'd0);
    chk("rst_sdin", 32'(sdin_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_dc",   32'(dc_a),   32'd0);
    reset = 1'b0;

    // Idle with no requests
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (cs_n_a !== 1'b1 || sclk_a !== 1'b0 || done_a !== 1'b0 || busy_a !== 1'b0) bad = 1;
    end
    chk("idle_quiet", 32'(bad), 32'd0);
    chk("idle_done_count", 32'(dcnt_a), 32'd0);

    run_byte(1'b0, 8'hAE, 1'b0, 1, 8'h00, "cmd_ae");
    run_byte(1'b1, 8'hA5, 1'b1, 1, 8'h00, "fast_a5");

    // Input changes and request drop mid-byte are ignored
    run_byte(1'b0, 8'h3C, 1'b0, 10, 8'hFF, "drop_3c");

    // Init-style requester holding spi_send high, advancing on send_done
    seq[0] = 8'hAE; seq[1] = 8'hD5; seq[2] = 8'h80;
    sel = 1'b0;
    @(negedge clk);
    q_a.delete(); acc_a.delete();
    data = seq[0]; dc_in = 1'b0; send_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      got = 0;
      for (int n = 0; n < 400 && !got; n++) begin
        @(negedge clk);
        if (done_a === 1'b1) got = 1;
      end
      chk("b2b_done_seen", 32'(got), 32'd1);
      if (k < 2) data = seq[k + 1];
      else send_a = 1'b0;
    end
    repeat (5) @(negedge clk);
    chk("b2b_nbytes", 32'(q_a.size()), 32'd3);
    chk("b2b_nacc", 32'(acc_a.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      rd = (q_a.size() > k) ? q_a[k] : 8'hxx;
      chk($sformatf("b2b_byte%0d", k), 32'(rd), 32'(seq[k]));
    end
    if (acc_a.size() == 3) begin
      chk("b2b_period1", 32'(acc_a[1] - acc_a[0]), 32'd68);
      chk("b2b_period2", 32'(acc_a[2] - acc_a[1]), 32'd68);
    end

    // Reset in the middle of a byte
    @(negedge clk);
    q_a.delete();
    d0 = dcnt_a;
    data = 8'h55; dc_in = 1'b1; send_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    send_a = 1'b0;
    repeat (29) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_cs_n", 32'(cs_n_a), 32'd1);
    chk("abort_sclk", 32'(sclk_a), 32'd0);
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_done", 32'(done_a), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (80) @(negedge clk);
    chk("abort_no_done", 32'(dcnt_a - d0), 32'd0);
    chk("abort_no_byte", 32'(q_a.size()), 32'd0);
    run_byte(1'b0, 8'hC3, 1'b0, 1, 8'h00, "post_reset");

    // Random bytes on both divider settings
    for (int i = 0; i < 4; i++)
      run_byte(1'b0, 8'($urandom), 1'($urandom), 1 + int'($urandom_range(0, 40)), 8'($urandom),
               $sformatf("rnd_a%0d", i));
    for (int i = 0; i < 3; i++)
      run_byte(1'b1, 8'($urandom), 1'($urandom), 1 + int'($urandom_range(0, 10)), 8'($urandom),
               $sformatf("rnd_b%0d", i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/oled_spi_tx.md
# oled_spi_tx

SPI byte transmitter for the SSD1306 OLED panel, the serialising end of the `spi_send`/`spi_data`/`send_done` handshake used by the OLED init sequencer and the pixel writer. It accepts one byte and a D/C flag, shifts the byte MSB-first in SPI mode 0 (CPOL=0, CPHA=0) on a divided clock, and frames it with chip-select. After each byte it pulses `send_done` so the requesting FSM can advance.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per SCLK half-period; legal range 1..255.
- `CS_GAP`, default 2: `clk` cycles that `oled_cs_n` stays high after each byte, before `send_done`; legal range 1..255.

Ports (name, direction, width, meaning):
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-high.
- `spi_send` input 1: byte request, level-sensitive; requester may hold it high across bytes.
- `spi_data` input 8: byte to send; sampled only on acceptance.
- `dc_in` input 1: 0 = command, 1 = display data; sampled on acceptance.
- `send_done` output 1: one-cycle pulse when the byte is fully sent.
- `busy` output 1: high from acceptance through the `send_done` cycle.
- `oled_sclk` output 1: SPI clock; idles low.
- `oled_sdin` output 1: SPI MOSI.
- `oled_cs_n` output 1: chip-select, active low.
- `oled_dc` output 1: D/C line to the panel.

## Operation
- States: IDLE, SHIFT, GAP, DONE.
- IDLE: if `spi_send`=1 at a clk edge, this is acceptance:
  - shift reg <= `spi_data`; `oled_dc` <= `dc_in`; `oled_cs_n` <= 0.
  - bit_cnt <= 7; div_cnt <= 0; go to SHIFT.
- SHIFT: `oled_sdin` = shift reg[7].
  - Each bit: SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - On the high-to-low transition the shift reg shifts left and bit_cnt decrements.
  - After the 8th high phase: SCLK <= 0, `oled_cs_n` <= 1, go to GAP.
- GAP: count CS_GAP cycles with `oled_cs_n`=1 and SCLK=0, then go to DONE.
- DONE: `send_done`=1 for exactly one cycle, then return to IDLE unconditionally.
  - IDLE does not re-sample `spi_send` in the DONE cycle. The requester updates `spi_data` on that edge, so the next byte is taken fresh.
- `spi_send` deasserting mid-byte is ignored: the byte completes and `send_done` still pulses.
- `spi_data` and `dc_in` changes after acceptance have no effect.
- `oled_dc` holds its latched value until the next acceptance.
- `oled_sdin` is 0 in IDLE, GAP and DONE.
- Counters: div_cnt is 8 bits and wraps at CLK_DIV-1; bit_cnt is 3 bits and does not wrap past 0 (the exit condition is bit_cnt==0 at the end of the high phase).

## Timing
- Reset values (asynchronous): state=IDLE, `send_done`=0, `busy`=0, `oled_sclk`=0, `oled_sdin`=0, `oled_cs_n`=1, `oled_dc`=0, shift reg=0.
- Reset mid-byte aborts immediately to reset values; no `send_done` is issued.
- Let acceptance edge = E0, and cycle n = the nth cycle after E0.
  - SHIFT occupies cycles 1..16·CLK_DIV.
  - GAP occupies the next CS_GAP cycles.
  - `send_done` is high in cycle 16·CLK_DIV+CS_GAP+1.
- Back-to-back byte period with `spi_send` held high: 16·CLK_DIV+CS_GAP+2 cycles. Defaults give 68.
- The first SCLK rising edge is CLK_DIV cycles after `oled_cs_n` falls, so MOSI setup is CLK_DIV cycles.
- MOSI changes only while SCLK is low. The panel samples on the rising edge.

## Structure
- Shared package `oled_pkg`:
  - state enum for this block;
  - SSD1306 command byte constants (0xAE, 0xAF, 0xD5, 0x80, 0x8D, 0x14, 0x81, 0xCF, 0xD9, 0xF1, 0xA0), shared with the init sequencer;
  - `DC_CMD`=0, `DC_DATA`=1.
- One sub-module: `oled_sclk_div`, which generates a half-period tick every CLK_DIV cycles. It is enabled only in SHIFT and cleared on acceptance.

## Test plan
- Reset then idle, `spi_send`=0 for 100 cycles -> `oled_cs_n`=1, SCLK=0, `send_done` never asserts.
- Defaults, `spi_data`=0xAE, `dc_in`=0, one request -> MOSI bits 1,0,1,0,1,1,1,0 at the 8 SCLK rising edges, `oled_dc`=0, `send_done` in cycle 67 after acceptance, exactly one pulse.
- `spi_send` held high, init-style requester advancing 0xAE, 0xD5, 0x80 on `send_done` -> three distinct bytes decoded, acceptances 68 cycles apart, no duplicated byte.
- CLK_DIV=1, CS_GAP=1, `spi_data`=0xA5, `dc_in`=1 -> SCLK toggles every cycle, `send_done` in cycle 18, `oled_dc`=1 through the byte.
- Change `spi_data` to 0xFF and drop `spi_send` at cycle 10 of a 0x3C byte -> 0x3C is still transmitted intact and `send_done` still pulses.
- Assert `reset` at cycle 30 of a byte -> same-cycle `oled_cs_n`=1, SCLK=0, `busy`=0, no `send_done`; the next request after release sends a full byte.
